frame_buffer_pingpong: RTL and testbench

- Double-buffered (ping-pong) multi-channel pixel frame buffer, single clock.
- A camera/filter stage streams one frame of pixels into the write bank. Downstream image filters randomly read the other bank by address.
- Banks swap only when a complete frame is written and the reader has released its bank.
- Successor of the fixed 8-bit RGB 4096-entry RAM: parametrised width, channel count and depth, plus write addressing, frame handshake and bank control.

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_bank_ram.sv | 27 ++
 rtl/frame_buffer_pingpong.sv | 133 +++++++++++++
 tb/tb_frame_buffer_pingpong.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants for the ping-pong frame buffer: write-FSM encodings,
// channel indices and the packed-pixel width helper.
package fb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  function automatic int pix_w(input int data_width, input int num_ch);
    return data_width * num_ch;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One frame bank: simple dual-port RAM with one write port and one
// registered, enable-gated read port on a single clock.
module fb_bank_ram
  import fb_pkg::*;
#(
  parameter int WIDTH     = pix_w(8, 3),
  parameter int ADD_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADD_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADD_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADD_WIDTH];

  // NOTE: the array and its read register have no reset so this maps onto block RAM;
  // the top masks rdata until a valid read has been issued.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame buffer: a writer fills one bank while readers randomly
// access the other; banks swap once a frame is complete and the reader lets go.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int ADD_WIDTH  = 12,
  parameter int FRAME_PIX  = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_valid,
  input  logic                                wr_sof,
  input  logic [pix_w(DATA_WIDTH, NUM_CH)-1:0] wr_data,
  output logic                                wr_ready,
  input  logic                                rd_en,
  input  logic [ADD_WIDTH-1:0]                rd_addr,
  output logic [pix_w(DATA_WIDTH, NUM_CH)-1:0] rd_data,
  output logic                                rd_valid,
  input  logic                                rd_frame_done,
  output logic                                frame_avail,
  output logic                                rd_bank,
  output logic                                restart
);

  localparam int PIX_W = pix_w(DATA_WIDTH, NUM_CH);
  // One extra bit so FRAME_PIX == 2**ADD_WIDTH is representable.
  localparam int CNT_W = ADD_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_PIX);

  logic [1:0]           state;
  logic [CNT_W-1:0]     wcnt;
  logic                 accept;
  logic                 swap;
  logic                 wr_en;
  logic [ADD_WIDTH-1:0] wr_addr;
  logic                 rd_in_range;
  logic                 rd_sel_q;
  logic                 rd_zero_q;
  logic [PIX_W-1:0]     q0;
  logic [PIX_W-1:0]     q1;

  assign wr_ready    = (state != ST_FULL);
  assign accept      = wr_valid && wr_ready;
  assign swap        = (state == ST_FULL) && (!frame_avail || rd_frame_done);
  assign wr_en       = accept && ((state == ST_FILL) || wr_sof);
  assign wr_addr     = wr_sof ? '0 : wcnt[ADD_WIDTH-1:0];
  assign rd_in_range = ({1'b0, rd_addr} < FRAME_LEN);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes the swap-cycle read see the old bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      restart     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_avail <= 1'b0;
    end else begin
      restart <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && wr_sof) begin
            wcnt  <= CNT_W'(1);
            state <= (FRAME_PIX == 1) ? ST_FULL : ST_FILL;
          end
        end
        ST_FILL: begin
          if (accept) begin
            if (wr_sof) begin
              wcnt    <= CNT_W'(1);
              restart <= 1'b1;
            end else begin
              wcnt <= wcnt + CNT_W'(1);
              if (wcnt == LAST_IDX) state <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (swap) begin
            rd_bank <= ~rd_bank;
            wcnt    <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (swap)               frame_avail <= 1'b1;
      else if (rd_frame_done) frame_avail <= 1'b0;
    end
  end

  // Out-of-range flag resets to 1 so rd_data reads as zero before any read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel_q  <= rd_bank;
        rd_zero_q <= !rd_in_range;
      end
    end
  end

  assign rd_data = rd_zero_q ? '0 : (rd_sel_q ? q1 : q0);

  fb_bank_ram #(.WIDTH(PIX_W), .ADD_WIDTH(ADD_WIDTH)) u_bank0 (
    .clk   (clk),
    .we    (wr_en && rd_bank),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en && rd_in_range && !rd_bank),
    .raddr (rd_addr),
    .rdata (q0)
  );

  fb_bank_ram #(.WIDTH(PIX_W), .ADD_WIDTH(ADD_WIDTH)) u_bank1 (
    .clk   (clk),
    .we    (wr_en && !rd_bank),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en && rd_in_range && rd_bank),
    .raddr (rd_addr),
    .rdata (q1)
  );

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Scenario bench for the ping-pong frame buffer: a bank model supplies
// expected read data, queued at issue and compared when rd_valid returns.
module tb_frame_buffer_pingpong;
  import fb_pkg::*;

  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int AW  = 5;
  localparam int FP  = 16;
  localparam int PW  = DW * NCH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_sof = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [PW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_frame_done = 1'b0;
  logic          frame_avail;
  logic          rd_bank;
  logic          restart;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] model_mem [2][FP];
  logic          model_rd_bank = 1'b1;

  frame_buffer_pingpong #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADD_WIDTH(AW), .FRAME_PIX(FP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_sof        (wr_sof),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_frame_done (rd_frame_done),
    .frame_avail   (frame_avail),
    .rd_bank       (rd_bank),
    .restart       (restart)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [PW-1:0] pix(input int i, input logic [7:0] base);
    logic [PW-1:0] p;
    p = '0;
    p[CH_R*DW +: DW] = base + 8'(i);
    p[CH_G*DW +: DW] = base + 8'(i + 1);
    p[CH_B*DW +: DW] = base + 8'(i + 2);
    return p;
  endfunction

  function automatic logic [PW-1:0] exp_rd(input int addr);
    if (addr >= FP) return '0;
    return model_mem[model_rd_bank ? 1 : 0][addr];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pix(input logic [PW-1:0] d, input logic sof);
    wr_valid = 1'b1;
    wr_sof   = sof;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] base, input int first, input int last);
    int wb;
    wb = model_rd_bank ? 0 : 1;
    for (int i = first; i <= last; i++) begin
      model_mem[wb][i] = pix(i, base);
      wr_pix(pix(i, base), i == 0);
    end
  endtask

  task automatic rd_read(input int addr, input string tag);
    logic [PW-1:0] want;
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(exp_rd(addr));
    cyc();
    rd_en = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s rd_valid: got %b want 1", tag, rd_valid);
    end
    checks++;
    if (rd_data !== want) begin
      failures++;
      $display("FAIL %s rd_data[%0d]: got %h want %h", tag, addr, rd_data, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({rd_bank, frame_avail, rd_valid, restart, wr_ready} !== 5'b10001) begin
      failures++;
      $display("FAIL reset flags {rd_bank,avail,valid,restart,ready}: got %b want 10001",
               {rd_bank, frame_avail, rd_valid, restart, wr_ready});
    end
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset rd_data: got %h want 0", rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_fill_swap();
    wr_frame(8'h00, 0, 14);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill ready_before_last: got %b want 1", wr_ready);
    end
    wr_frame(8'h00, 15, 15);
    checks++;
    if ({wr_ready, rd_bank, frame_avail} !== 3'b010) begin
      failures++;
      $display("FAIL fill full_state {ready,bank,avail}: got %b want 010", {wr_ready, rd_bank, frame_avail});
    end
    cyc();
    checks++;
    if ({wr_ready, rd_bank, frame_avail} !== 3'b101) begin
      failures++;
      $display("FAIL fill swap {ready,bank,avail}: got %b want 101", {wr_ready, rd_bank, frame_avail});
    end
    model_rd_bank = 1'b0;
    rd_read(5, "fill_read5");
    cyc();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== pix(5, 8'h00)) begin
      failures++;
      $display("FAIL fill hold: got valid=%b data=%h want valid=0 data=%h", rd_valid, rd_data, pix(5, 8'h00));
    end
  endtask

  task automatic test_backpressure();
    wr_frame(8'h40, 0, FP - 1);
    wr_valid = 1'b1;
    wr_data  = '1;
    repeat (3) cyc();
    wr_valid = 1'b0;
    checks++;
    if ({wr_ready, rd_bank, frame_avail} !== 3'b001) begin
      failures++;
      $display("FAIL bp stall {ready,bank,avail}: got %b want 001", {wr_ready, rd_bank, frame_avail});
    end
    rd_frame_done = 1'b1;
    cyc();
    rd_frame_done = 1'b0;
    checks++;
    if ({wr_ready, rd_bank, frame_avail} !== 3'b111) begin
      failures++;
      $display("FAIL bp swap {ready,bank,avail}: got %b want 111", {wr_ready, rd_bank, frame_avail});
    end
    model_rd_bank = 1'b1;
    rd_read(5, "bp_read5");
    rd_read(15, "bp_read15");
  endtask

  task automatic test_restart();
    int wb;
    wb = model_rd_bank ? 0 : 1;
    wr_frame(8'h80, 0, 6);
    model_mem[wb][0] = {PW/8{8'hAA}};
    wr_pix({PW/8{8'hAA}}, 1'b1);
    checks++;
    if (restart !== 1'b1) begin
      failures++;
      $display("FAIL restart pulse: got %b want 1", restart);
    end
    wr_frame(8'h80, 1, 1);
    checks++;
    if (restart !== 1'b0) begin
      failures++;
      $display("FAIL restart width: got %b want 0", restart);
    end
    wr_frame(8'h80, 2, 14);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart ready_at_15: got %b want 1", wr_ready);
    end
    wr_frame(8'h80, 15, 15);
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL restart ready_at_16: got %b want 0", wr_ready);
    end
    rd_frame_done = 1'b1;
    cyc();
    rd_frame_done = 1'b0;
    model_rd_bank = ~model_rd_bank;
    checks++;
    if (rd_bank !== model_rd_bank || frame_avail !== 1'b1) begin
      failures++;
      $display("FAIL restart swap: got bank=%b avail=%b want bank=%b avail=1", rd_bank, frame_avail, model_rd_bank);
    end
    rd_read(0, "restart_read0");
    rd_read(9, "restart_read9");
  endtask

  task automatic test_drop_oob();
    rd_frame_done = 1'b1;
    cyc();
    rd_frame_done = 1'b0;
    checks++;
    if (frame_avail !== 1'b0) begin
      failures++;
      $display("FAIL release avail: got %b want 0", frame_avail);
    end
    for (int i = 0; i < 3; i++) wr_pix(pix(i, 8'h11), 1'b0);
    checks++;
    if (wr_ready !== 1'b1 || restart !== 1'b0) begin
      failures++;
      $display("FAIL drop state: got ready=%b restart=%b want ready=1 restart=0", wr_ready, restart);
    end
    rd_read(20, "oob_read20");
  endtask

  task automatic test_back_to_back_swap_read();
    wr_frame(8'hC0, 0, 14);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL swapread ready_at_15: got %b want 1", wr_ready);
    end
    wr_frame(8'hC0, 15, 15);
    checks++;
    if (wr_ready !== 1'b0 || frame_avail !== 1'b0) begin
      failures++;
      $display("FAIL swapread full: got ready=%b avail=%b want 0 0", wr_ready, frame_avail);
    end
    rd_read(9, "swapcycle_read9");
    model_rd_bank = ~model_rd_bank;
    checks++;
    if (rd_bank !== model_rd_bank || frame_avail !== 1'b1) begin
      failures++;
      $display("FAIL swapread swap: got bank=%b avail=%b want bank=%b avail=1", rd_bank, frame_avail, model_rd_bank);
    end
    rd_read(9, "newbank_read9");
  endtask

  task automatic test_async_reset();
    wr_frame(8'h20, 0, 4);
    rd_read(3, "prereset_read3");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_bank, frame_avail, rd_valid, restart, wr_ready} !== 5'b10001 || rd_data !== '0) begin
      failures++;
      $display("FAIL async_reset: got flags=%b data=%h want flags=10001 data=0",
               {rd_bank, frame_avail, rd_valid, restart, wr_ready}, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    model_rd_bank = 1'b1;
    wr_frame(8'h50, 0, FP - 1);
    checks++;
    if (frame_avail !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL postreset full: got avail=%b ready=%b want 0 0", frame_avail, wr_ready);
    end
    cyc();
    checks++;
    if (frame_avail !== 1'b1 || rd_bank !== 1'b0) begin
      failures++;
      $display("FAIL postreset swap: got avail=%b bank=%b want 1 0", frame_avail, rd_bank);
    end
    model_rd_bank = 1'b0;
    rd_read(2, "postreset_read2");
  endtask

  initial begin
    test_reset();
    test_fill_swap();
    test_backpressure();
    test_restart();
    test_drop_oob();
    test_back_to_back_swap_read();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
